// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin between the ALU and load paths, with one
// overflow FIFO per source and a single registered broadcast per cycle.
module cdb_arbiter #(
    parameter int DEPTH     = 4,
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 jump_wrong,
    input  logic                 alu_valid,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    input  logic [DATA_W-1:0]    alu_val,
    output logic                 alu_full,
    input  logic                 lsb_valid,
    input  logic [ROB_POS_W-1:0] lsb_rob_pos,
    input  logic [DATA_W-1:0]    lsb_val,
    output logic                 lsb_full,
    output logic                 cdb_valid,
    output logic [ROB_POS_W-1:0] cdb_rob_pos,
    output logic [DATA_W-1:0]    cdb_val,
    output logic                 cdb_src,
    output logic                 err_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    logic [ROB_POS_W-1:0] alu_pos_mem [DEPTH];
    logic [DATA_W-1:0]    alu_val_mem [DEPTH];
    logic [ROB_POS_W-1:0] lsb_pos_mem [DEPTH];
    logic [DATA_W-1:0]    lsb_val_mem [DEPTH];

    logic [PTR_W-1:0] alu_rd_ptr, alu_wr_ptr, lsb_rd_ptr, lsb_wr_ptr;
    logic [CNT_W-1:0] alu_cnt, lsb_cnt;
    logic             last_grant;

    logic alu_nonempty, lsb_nonempty;
    logic alu_cand, lsb_cand;
    logic grant_alu, grant_lsb, grant_any;
    logic alu_pop, lsb_pop, alu_push, lsb_push, alu_ovf, lsb_ovf;
    logic advance;
    logic [ROB_POS_W-1:0] win_pos;
    logic [DATA_W-1:0]    win_val;

    assign advance      = rdy && !jump_wrong;
    assign alu_full     = (alu_cnt == CNT_FULL);
    assign lsb_full     = (lsb_cnt == CNT_FULL);
    assign alu_nonempty = (alu_cnt != '0);
    assign lsb_nonempty = (lsb_cnt != '0);

    // A buffered head always beats that source's same-cycle input.
    assign alu_cand  = alu_nonempty || alu_valid;
    assign lsb_cand  = lsb_nonempty || lsb_valid;
    assign grant_alu = alu_cand && (!lsb_cand || (last_grant == SRC_LSB));
    assign grant_lsb = lsb_cand && !grant_alu;
    assign grant_any = grant_alu || grant_lsb;

    assign alu_pop  = grant_alu && alu_nonempty;
    assign lsb_pop  = grant_lsb && lsb_nonempty;

    // Input is buffered unless it bypassed straight to the bus; a full FIFO
    // only accepts it when its head leaves in the same cycle.
    assign alu_push = alu_valid && !(grant_alu && !alu_nonempty) && (!alu_full || alu_pop);
    assign lsb_push = lsb_valid && !(grant_lsb && !lsb_nonempty) && (!lsb_full || lsb_pop);
    assign alu_ovf  = alu_valid && alu_full && !alu_pop;
    assign lsb_ovf  = lsb_valid && lsb_full && !lsb_pop;

    always_comb begin
        win_pos = '0;
        win_val = '0;
        if (grant_alu) begin
            win_pos = alu_nonempty ? alu_pos_mem[alu_rd_ptr] : alu_rob_pos;
            win_val = alu_nonempty ? alu_val_mem[alu_rd_ptr] : alu_val;
        end else if (grant_lsb) begin
            win_pos = lsb_nonempty ? lsb_pos_mem[lsb_rd_ptr] : lsb_rob_pos;
            win_val = lsb_nonempty ? lsb_val_mem[lsb_rd_ptr] : lsb_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && advance) begin
            if (alu_push) begin
                alu_pos_mem[alu_wr_ptr] <= alu_rob_pos;
                alu_val_mem[alu_wr_ptr] <= alu_val;
            end
            if (lsb_push) begin
                lsb_pos_mem[lsb_wr_ptr] <= lsb_rob_pos;
                lsb_val_mem[lsb_wr_ptr] <= lsb_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_rd_ptr   <= '0;
            alu_wr_ptr   <= '0;
            alu_cnt      <= '0;
            lsb_rd_ptr   <= '0;
            lsb_wr_ptr   <= '0;
            lsb_cnt      <= '0;
            last_grant   <= SRC_LSB;
            cdb_valid    <= 1'b0;
            cdb_rob_pos  <= '0;
            cdb_val      <= '0;
            cdb_src      <= SRC_ALU;
            err_overflow <= 1'b0;
        end else if (rdy) begin
            if (jump_wrong) begin
                alu_rd_ptr <= '0;
                alu_wr_ptr <= '0;
                alu_cnt    <= '0;
                lsb_rd_ptr <= '0;
                lsb_wr_ptr <= '0;
                lsb_cnt    <= '0;
                last_grant <= SRC_LSB;
                cdb_valid  <= 1'b0;
            end else begin
                if (alu_push) alu_wr_ptr <= alu_wr_ptr + 1'b1;
                if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + 1'b1;
                if (lsb_push) lsb_wr_ptr <= lsb_wr_ptr + 1'b1;
                if (lsb_pop)  lsb_rd_ptr <= lsb_rd_ptr + 1'b1;
                alu_cnt   <= alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);
                lsb_cnt   <= lsb_cnt + CNT_W'(lsb_push) - CNT_W'(lsb_pop);
                cdb_valid <= grant_any;
                if (grant_any) begin
                    cdb_rob_pos <= win_pos;
                    cdb_val     <= win_val;
                    cdb_src     <= grant_lsb;
                    last_grant  <= grant_lsb;
                end
                if (alu_ovf || lsb_ovf) err_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of the bus scheduling rules.
module tb_cdb_arbiter;
    localparam int DEPTH = 4;
    localparam int PW    = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst, rdy, jump_wrong;
    logic          alu_valid, lsb_valid;
    logic [PW-1:0] alu_rob_pos, lsb_rob_pos;
    logic [DW-1:0] alu_val, lsb_val;
    logic          alu_full, lsb_full;
    logic          cdb_valid, cdb_src, err_overflow;
    logic [PW-1:0] cdb_rob_pos;
    logic [DW-1:0] cdb_val;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [PW-1:0] pos;
        logic [DW-1:0] val;
    } res_t;

    res_t          q_alu[$];
    res_t          q_lsb[$];
    logic          m_last;   // 1 = LSB was granted last
    logic          m_err, m_valid, m_src;
    logic [PW-1:0] m_pos;
    logic [DW-1:0] m_val;

    cdb_arbiter #(.DEPTH(DEPTH), .ROB_POS_W(PW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .alu_valid(alu_valid), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val), .alu_full(alu_full),
        .lsb_valid(lsb_valid), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val), .cdb_src(cdb_src),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the reference model, then sample after the edge.
    task automatic step(input logic r, input logic rd, input logic jw,
                        input logic av, input logic [PW-1:0] ap, input logic [DW-1:0] avl,
                        input logic lv, input logic [PW-1:0] lp, input logic [DW-1:0] lvl);
        logic ac, lc, a_used, l_used;
        int   win;
        res_t it, a_in, l_in;
        rst = r; rdy = rd; jump_wrong = jw;
        alu_valid = av; alu_rob_pos = ap; alu_val = avl;
        lsb_valid = lv; lsb_rob_pos = lp; lsb_val = lvl;
        a_in.pos = ap; a_in.val = avl;
        l_in.pos = lp; l_in.val = lvl;
        it = '0;
        if (r) begin
            q_alu.delete(); q_lsb.delete();
            m_last = 1'b1; m_err = 1'b0; m_valid = 1'b0; m_src = 1'b0; m_pos = '0; m_val = '0;
        end else if (rd) begin
            if (jw) begin
                q_alu.delete(); q_lsb.delete();
                m_valid = 1'b0; m_last = 1'b1;
            end else begin
                ac = (q_alu.size() > 0) || av;
                lc = (q_lsb.size() > 0) || lv;
                win = -1;
                if (ac && lc)  win = m_last ? 0 : 1;
                else if (ac)   win = 0;
                else if (lc)   win = 1;
                a_used = 1'b0; l_used = 1'b0;
                if (win == 0) begin
                    if (q_alu.size() > 0) it = q_alu.pop_front();
                    else begin it = a_in; a_used = 1'b1; end
                    m_src = 1'b0; m_last = 1'b0;
                end else if (win == 1) begin
                    if (q_lsb.size() > 0) it = q_lsb.pop_front();
                    else begin it = l_in; l_used = 1'b1; end
                    m_src = 1'b1; m_last = 1'b1;
                end
                m_valid = (win >= 0);
                if (win >= 0) begin m_pos = it.pos; m_val = it.val; end
                if (av && !a_used) begin
                    if (q_alu.size() < DEPTH) q_alu.push_back(a_in); else m_err = 1'b1;
                end
                if (lv && !l_used) begin
                    if (q_lsb.size() < DEPTH) q_lsb.push_back(l_in); else m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 32'h55, 1'b1, 4'h6, 32'h66);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        n_total++;
        if ({cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full, err_overflow} !== 41'h0)
            $display("FAIL reset_outputs: got %0h want 0",
                     {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full, err_overflow});
        else n_pass++;
    endtask

    task automatic test_single_alu();
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h11, 1'b0, '0, '0);
        n_total++;
        if ({cdb_valid, cdb_src, cdb_rob_pos, cdb_val} !== {1'b1, 1'b0, 4'd3, 32'h11})
            $display("FAIL single_bypass: got v=%0b s=%0b pos=%0h val=%0h want v=1 s=0 pos=3 val=11",
                     cdb_valid, cdb_src, cdb_rob_pos, cdb_val);
        else n_pass++;
        idle();
        n_total++;
        if ({cdb_valid, cdb_rob_pos, alu_full, lsb_full} !== {1'b0, 4'd3, 1'b0, 1'b0})
            $display("FAIL single_idle: got v=%0b pos=%0h af=%0b lf=%0b want v=0 pos=3 af=0 lf=0",
                     cdb_valid, cdb_rob_pos, alu_full, lsb_full);
        else n_pass++;
    endtask

    task automatic test_tie();
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
        n_total++;
        if ({cdb_valid, cdb_src, cdb_rob_pos, cdb_val} !== {1'b1, 1'b0, 4'd1, 32'hA})
            $display("FAIL tie_first: got v=%0b s=%0b pos=%0h val=%0h want 1/0/1/a",
                     cdb_valid, cdb_src, cdb_rob_pos, cdb_val);
        else n_pass++;
        idle();
        n_total++;
        if ({cdb_valid, cdb_src, cdb_rob_pos, cdb_val} !== {1'b1, 1'b1, 4'd2, 32'hB})
            $display("FAIL tie_second: got v=%0b s=%0b pos=%0h val=%0h want 1/1/2/b",
                     cdb_valid, cdb_src, cdb_rob_pos, cdb_val);
        else n_pass++;
        idle();
        n_total++;
        if (cdb_valid !== 1'b0) $display("FAIL tie_drained: got v=%0b want 0", cdb_valid);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int   sent_a, sent_l, got_a, got_l;
        logic seen_full, av, lv, done;
        sent_a = 0; sent_l = 0; got_a = 0; got_l = 0; seen_full = 1'b0; done = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 16; k++) begin
            av = !alu_full; lv = !lsb_full;
            step(1'b0, 1'b1, 1'b0, av, PW'(sent_a), 32'hA000_0000 + 32'(sent_a),
                 lv, PW'(sent_l), 32'hB000_0000 + 32'(sent_l));
            if (av) sent_a++;
            if (lv) sent_l++;
            if (alu_full || lsb_full) seen_full = 1'b1;
            n_total++;
            if ({cdb_valid, cdb_src} !== {1'b1, 1'(k % 2)})
                $display("FAIL sat_alternate: cycle %0d got v=%0b s=%0b want v=1 s=%0d",
                         k, cdb_valid, cdb_src, k % 2);
            else n_pass++;
            n_total++;
            if (cdb_src == 1'b0) begin
                if ({cdb_rob_pos, cdb_val} !== {PW'(got_a), 32'hA000_0000 + 32'(got_a)})
                    $display("FAIL sat_alu_order: got pos=%0h val=%0h want pos=%0h", cdb_rob_pos, cdb_val, got_a);
                else n_pass++;
                got_a++;
            end else begin
                if ({cdb_rob_pos, cdb_val} !== {PW'(got_l), 32'hB000_0000 + 32'(got_l)})
                    $display("FAIL sat_lsb_order: got pos=%0h val=%0h want pos=%0h", cdb_rob_pos, cdb_val, got_l);
                else n_pass++;
                got_l++;
            end
        end
        n_total++;
        if ({seen_full, err_overflow} !== 2'b10)
            $display("FAIL sat_flags: got seen_full=%0b err=%0b want 1/0", seen_full, err_overflow);
        else n_pass++;
        for (int i = 0; i < 20 && !done; i++) begin
            idle();
            if (!cdb_valid) done = 1'b1;
            else if (cdb_src == 1'b0) begin
                n_total++;
                if (cdb_rob_pos !== PW'(got_a))
                    $display("FAIL drain_alu_order: got %0h want %0h", cdb_rob_pos, got_a);
                else n_pass++;
                got_a++;
            end else begin
                n_total++;
                if (cdb_rob_pos !== PW'(got_l))
                    $display("FAIL drain_lsb_order: got %0h want %0h", cdb_rob_pos, got_l);
                else n_pass++;
                got_l++;
            end
        end
        n_total++;
        if (!done || got_a != sent_a || got_l != sent_l)
            $display("FAIL sat_no_loss: drained=%0b got alu=%0d lsb=%0d want alu=%0d lsb=%0d",
                     done, got_a, got_l, sent_a, sent_l);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic reached, av, lv;
        int   tag;
        reached = 1'b0; tag = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 30 && !reached; i++) begin
            if (q_alu.size() == DEPTH && m_last == 1'b0 && q_lsb.size() > 0) reached = 1'b1;
            else begin
                // ALU also sends while full on cycles it is about to win (pop + push).
                av = (q_alu.size() < DEPTH) || m_last;
                lv = (q_lsb.size() < DEPTH);
                step(1'b0, 1'b1, 1'b0, av, PW'(tag), 32'h100 + 32'(tag), lv, PW'(tag), 32'h200 + 32'(tag));
                tag++;
            end
        end
        n_total++;
        if (!reached || err_overflow !== 1'b0)
            $display("FAIL ovf_setup: reached=%0b err=%0b want 1/0", reached, err_overflow);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, '0, '0);
        n_total++;
        if ({cdb_valid, cdb_src, alu_full, err_overflow} !== 4'b1111)
            $display("FAIL ovf_cycle: got v=%0b s=%0b af=%0b err=%0b want 1/1/1/1",
                     cdb_valid, cdb_src, alu_full, err_overflow);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            idle();
            n_total++;
            if ((cdb_valid && cdb_val === 32'hDEAD_BEEF) || err_overflow !== 1'b1
                || {cdb_valid, cdb_src, cdb_rob_pos, cdb_val} !== {m_valid, m_src, m_pos, m_val})
                $display("FAIL ovf_drain: got v=%0b pos=%0h val=%0h err=%0b want v=%0b pos=%0h val=%0h err=1",
                         cdb_valid, cdb_rob_pos, cdb_val, err_overflow, m_valid, m_pos, m_val);
            else n_pass++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        n_total++;
        if (err_overflow !== 1'b0) $display("FAIL ovf_reset_clears: got %0b want 0", err_overflow);
        else n_pass++;
    endtask

    task automatic test_flush();
        int tag;
        tag = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 10 && (q_alu.size() + q_lsb.size()) < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, !alu_full, PW'(tag), 32'hF00 + 32'(tag),
                 !lsb_full, PW'(tag), 32'hF80 + 32'(tag));
            tag++;
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 4'hE, 32'hF1F1_F1F1);
        n_total++;
        if ({cdb_valid, alu_full, lsb_full, err_overflow} !== 4'b0000)
            $display("FAIL flush_cycle: got v=%0b af=%0b lf=%0b err=%0b want 0/0/0/0",
                     cdb_valid, alu_full, lsb_full, err_overflow);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            idle();
            n_total++;
            if (cdb_valid !== 1'b0) $display("FAIL flush_no_stale: got v=%0b pos=%0h want v=0", cdb_valid, cdb_rob_pos);
            else n_pass++;
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA);
        n_total++;
        if ({cdb_valid, cdb_src, cdb_rob_pos} !== {1'b1, 1'b0, 4'd9})
            $display("FAIL flush_last_grant: got v=%0b s=%0b pos=%0h want 1/0/9", cdb_valid, cdb_src, cdb_rob_pos);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [40:0] snap, got;
        int tag;
        tag = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, PW'(tag), 32'h300 + 32'(tag), 1'b1, PW'(tag), 32'h400 + 32'(tag));
            tag++;
        end
        snap = {m_valid, m_src, m_pos, m_val, q_alu.size() == DEPTH, q_lsb.size() == DEPTH, m_err};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'(i == 1), 1'(i % 2), 4'hC, 32'hCCCC, 1'(~i % 2), 4'hD, 32'hDDDD);
            got = {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full, err_overflow};
            n_total++;
            if (got !== snap) $display("FAIL stall_frozen: cycle %0d got %0h want %0h", i, got, snap);
            else n_pass++;
        end
        for (int i = 0; i < 12; i++) begin
            if (i < 3) step(1'b0, 1'b1, 1'b0, !alu_full, PW'(tag), 32'h300 + 32'(tag), 1'b0, '0, '0);
            else idle();
            tag++;
            got = {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full, err_overflow};
            n_total++;
            if (got !== {m_valid, m_src, m_pos, m_val, q_alu.size() == DEPTH, q_lsb.size() == DEPTH, m_err})
                $display("FAIL stall_resume: cycle %0d got %0h want %0h", i, got,
                         {m_valid, m_src, m_pos, m_val, q_alu.size() == DEPTH, q_lsb.size() == DEPTH, m_err});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [40:0] got, want;
        logic r_rdy, r_jw, av, lv;
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 400; i++) begin
            r_rdy = ($urandom_range(7) != 0);
            r_jw  = ($urandom_range(31) == 0);
            av = ($urandom_range(1) == 1) && ((q_alu.size() < DEPTH) || ($urandom_range(15) == 0));
            lv = ($urandom_range(1) == 1) && ((q_lsb.size() < DEPTH) || ($urandom_range(15) == 0));
            step(1'b0, r_rdy, r_jw, av, PW'($urandom), $urandom, lv, PW'($urandom), $urandom);
            got  = {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, alu_full, lsb_full, err_overflow};
            want = {m_valid, m_src, m_pos, m_val, q_alu.size() == DEPTH, q_lsb.size() == DEPTH, m_err};
            n_total++;
            if (got !== want) $display("FAIL random: cycle %0d got %0h want %0h", i, got, want);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_tie();
        test_saturate();
        test_overflow();
        test_flush();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
